// File: rtl/led_rate_ctrl.sv
// -----------------------------------------------------------------------------
// led_rate_ctrl
//
// Pushbutton front end for the LED blink counter. The raw button is
// synchronised into the clk100 domain and then debounced by a small FSM.
//   - short press (released before LONG_CNT cycles in PRESSED): the divider
//     steps to the next value, 1..DIV_MAX, and wraps from DIV_MAX to 1
//   - long press (held for LONG_CNT cycles): the divider is reloaded with
//     DIV_DEFAULT, even if it already holds that value
// Every divider update comes with a single-cycle write strobe, so the
// downstream counter restarts on the new rate straight away.
//
// Ports
//   clk100  in   1  system clock, 100 MHz, only clock of the block
//   rst     in   1  synchronous, active-high reset
//   btn_i   in   1  raw pushbutton, active-high, asynchronous and bouncy
//   div_o   out  5  divider value for the LED counter (registered)
//   wren_o  out  1  one-cycle strobe, high in the first cycle div_o holds a
//                   new value (registered)
//
// Parameters
//   DB_CNT       stable samples needed to accept a press or a release
//   LONG_CNT     cycles held in PRESSED before a long press fires
//   DIV_DEFAULT  divider value after reset and after a long press
//   DIV_MAX      highest divider value before wrapping back to 1
// -----------------------------------------------------------------------------
module led_rate_ctrl #(
    parameter logic [27:0] DB_CNT      = 28'd1_000_000,
    parameter logic [27:0] LONG_CNT    = 28'd100_000_000,
    parameter logic [4:0]  DIV_DEFAULT = 5'h05,
    parameter logic [4:0]  DIV_MAX     = 5'h14
) (
    input  logic       clk100,
    input  logic       rst,
    input  logic       btn_i,
    output logic [4:0] div_o,
    output logic       wren_o
);

    // Terminal counts: a state is left on the cycle the counter already
    // holds N-1, so the state dwells exactly N cycles.
    localparam logic [27:0] DB_LAST   = DB_CNT - 28'd1;
    localparam logic [27:0] LONG_LAST = LONG_CNT - 28'd1;
    localparam logic [27:0] CNT_SAT   = 28'hFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_PRESSED    = 3'd2,
        ST_HELD       = 3'd3,
        ST_DB_RELEASE = 3'd4
    } state_t;

    // Synchroniser stages; sync_btn_r is the only view of the button the
    // FSM ever uses.
    logic        sync_meta_r;
    logic        sync_btn_r;
    logic        btn_s;

    state_t      state_r;
    logic [27:0] cnt_r;
    logic        short_r;
    logic [4:0]  div_r;
    logic        wren_r;

    // Next divider value for a short press. Anything at or above DIV_MAX,
    // or an impossible 0, falls back to 1 so the output can never leave
    // the range 1..DIV_MAX.
    function automatic logic [4:0] next_div(input logic [4:0] cur);
        logic [4:0] nxt;
        if ((cur >= DIV_MAX) || (cur == 5'd0)) begin
            nxt = 5'd1;
        end else begin
            nxt = cur + 5'd1;
        end
        return nxt;
    endfunction

    // Saturating increment used while the button stays held after a long
    // press; the counter must never wrap back into a terminal count.
    function automatic logic [27:0] sat_inc(input logic [27:0] cur);
        logic [27:0] nxt;
        if (cur == CNT_SAT) begin
            nxt = cur;
        end else begin
            nxt = cur + 28'd1;
        end
        return nxt;
    endfunction

    assign btn_s = sync_btn_r;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clk100) begin
        if (rst) begin
            sync_meta_r <= 1'b0;
            sync_btn_r  <= 1'b0;
        end else begin
            sync_meta_r <= btn_i;
            sync_btn_r  <= sync_meta_r;
        end
    end

    // Debounce / press-classification FSM with registered divider and strobe.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 28'd0;
            short_r <= 1'b0;
            div_r   <= DIV_DEFAULT;
            wren_r  <= 1'b0;
        end else begin
            // The strobe is a pulse: only the update branches raise it.
            wren_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    cnt_r   <= 28'd0;
                    short_r <= 1'b0;
                    if (btn_s) begin
                        state_r <= ST_DB_PRESS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_DB_PRESS: begin
                    if (!btn_s) begin
                        // Glitch shorter than the debounce window: drop it.
                        state_r <= ST_IDLE;
                        cnt_r   <= 28'd0;
                    end else if (cnt_r == DB_LAST) begin
                        state_r <= ST_PRESSED;
                        cnt_r   <= 28'd0;
                    end else begin
                        state_r <= ST_DB_PRESS;
                        cnt_r   <= cnt_r + 28'd1;
                    end
                end

                ST_PRESSED: begin
                    if (!btn_s) begin
                        // Released before the long-press time: short press,
                        // acted on once the release has debounced.
                        state_r <= ST_DB_RELEASE;
                        cnt_r   <= 28'd0;
                        short_r <= 1'b1;
                    end else if (cnt_r == LONG_LAST) begin
                        // Long press: reload the default and strobe even if
                        // the value does not change.
                        state_r <= ST_HELD;
                        cnt_r   <= 28'd0;
                        div_r   <= DIV_DEFAULT;
                        wren_r  <= 1'b1;
                    end else begin
                        state_r <= ST_PRESSED;
                        cnt_r   <= cnt_r + 28'd1;
                    end
                end

                ST_HELD: begin
                    if (!btn_s) begin
                        // The long press already acted; the release must not.
                        state_r <= ST_DB_RELEASE;
                        cnt_r   <= 28'd0;
                        short_r <= 1'b0;
                    end else begin
                        state_r <= ST_HELD;
                        cnt_r   <= sat_inc(cnt_r);
                    end
                end

                ST_DB_RELEASE: begin
                    if (btn_s) begin
                        // Release bounce: restart the window, never go back
                        // to PRESSED.
                        state_r <= ST_DB_RELEASE;
                        cnt_r   <= 28'd0;
                    end else if (cnt_r == DB_LAST) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 28'd0;
                        short_r <= 1'b0;
                        if (short_r) begin
                            div_r  <= next_div(div_r);
                            wren_r <= 1'b1;
                        end else begin
                            div_r  <= div_r;
                            wren_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_DB_RELEASE;
                        cnt_r   <= cnt_r + 28'd1;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a clean idle state.
                    state_r <= ST_IDLE;
                    cnt_r   <= 28'd0;
                    short_r <= 1'b0;
                end
            endcase
        end
    end

    assign div_o  = div_r;
    assign wren_o = wren_r;

endmodule

// File: tb/tb_led_rate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_rate_ctrl
//
// Directed bench for led_rate_ctrl with DB_CNT = 4, LONG_CNT = 20,
// DIV_DEFAULT = 5, DIV_MAX = 20. Inputs change on the falling edge and
// outputs are checked on the falling edge. A monitor counts wren_o pulses,
// remembers the cycle of the latest one and flags back-to-back pulses.
//
// Latency bookkeeping: "start" is the number of rising edges seen when
// btn_i changes; a pulse recorded with cycle value P means the strobe was
// raised by rising edge number P, so P - start is the latency in cycles.
//   short press  : 2 sync + 1 (PRESSED->DB_RELEASE) + DB_CNT       = 7
//   long press   : 2 sync + 1 (IDLE->DB_PRESS) + DB_CNT + LONG_CNT = 27
//   release after a 1-cycle glitch: the glitch already cleared the
//   window, so the transition cycle is not repeated                = 6
// -----------------------------------------------------------------------------
module tb_led_rate_ctrl;

    logic       clk100 = 1'b0;
    logic       rst    = 1'b1;
    logic       btn_i  = 1'b0;
    logic [4:0] div_o;
    logic       wren_o;

    int checks         = 0;
    int failures       = 0;
    int cyc            = 0;
    int pulse_cnt      = 0;
    int last_pulse_cyc = -1;
    int consec_err     = 0;
    logic prev_wren    = 1'b0;

    int start;
    int p0;
    logic [4:0] exp_div;

    led_rate_ctrl #(
        .DB_CNT      (28'd4),
        .LONG_CNT    (28'd20),
        .DIV_DEFAULT (5'd5),
        .DIV_MAX     (5'd20)
    ) dut (
        .clk100 (clk100),
        .rst    (rst),
        .btn_i  (btn_i),
        .div_o  (div_o),
        .wren_o (wren_o)
    );

    always #5 clk100 = ~clk100;

    // Pulse monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk100) begin
        cyc = cyc + 1;
        #1;
        if (wren_o === 1'b1) begin
            pulse_cnt      = pulse_cnt + 1;
            last_pulse_cyc = cyc;
            if (prev_wren) consec_err = consec_err + 1;
        end
        prev_wren = (wren_o === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk100);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        btn_i = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    // Clean press: high for 'high' cycles, then low for 'low' cycles.
    // 'start' is captured at the falling edge of btn_i.
    task automatic short_press(input int high, input int low);
        btn_i = 1'b1;
        step(high);
        btn_i = 1'b0;
        start = cyc;
        step(low);
    endtask

    initial begin
        // 1. Reset with a toggling button.
        rst = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            btn_i = ~btn_i;
            step(1);
            check("rst_div", {27'd0, div_o}, 32'd5);
            check("rst_wren", {31'd0, wren_o}, 32'd0);
        end
        btn_i = 1'b0;
        rst   = 1'b0;
        p0    = pulse_cnt;
        step(20);
        check("rst_no_pulse", pulse_cnt - p0, 32'd0);
        check("rst_div_after", {27'd0, div_o}, 32'd5);

        // 2. Clean short press.
        p0 = pulse_cnt;
        short_press(10, 20);
        check("short_pulses", pulse_cnt - p0, 32'd1);
        check("short_latency", last_pulse_cyc - start, 32'd7);
        check("short_div", {27'd0, div_o}, 32'd6);

        // 3a. Press bounce shorter than the debounce window.
        do_reset();
        p0 = pulse_cnt;
        btn_i = 1'b1; step(2);
        btn_i = 1'b0; step(2);
        btn_i = 1'b1; step(1);
        btn_i = 1'b0; step(20);
        check("bounce_pulses", pulse_cnt - p0, 32'd0);
        check("bounce_div", {27'd0, div_o}, 32'd5);

        // 3b. Release with a one-cycle high glitch.
        p0 = pulse_cnt;
        btn_i = 1'b1; step(10);
        btn_i = 1'b0; step(2);
        btn_i = 1'b1; step(1);
        btn_i = 1'b0;
        start = cyc;
        step(20);
        check("glitch_pulses", pulse_cnt - p0, 32'd1);
        check("glitch_latency", last_pulse_cyc - start, 32'd6);
        check("glitch_div", {27'd0, div_o}, 32'd6);

        // 4. Wrap: 16 short presses from reset, 5 -> ... -> 20 -> 1.
        do_reset();
        p0      = pulse_cnt;
        exp_div = 5'd5;
        for (int i = 1; i <= 16; i++) begin
            short_press(8, 12);
            exp_div = (exp_div == 5'd20) ? 5'd1 : exp_div + 5'd1;
            check("wrap_div", {27'd0, div_o}, {27'd0, exp_div});
        end
        check("wrap_last", {27'd0, div_o}, 32'd1);
        check("wrap_pulses", pulse_cnt - p0, 32'd16);

        // 5. Long press from div_o = 9.
        do_reset();
        for (int i = 0; i < 4; i++) short_press(8, 12);
        check("long_pre_div", {27'd0, div_o}, 32'd9);
        p0 = pulse_cnt;
        btn_i = 1'b1;
        start = cyc;
        step(40);
        btn_i = 1'b0;
        step(20);
        check("long_pulses", pulse_cnt - p0, 32'd1);
        check("long_latency", last_pulse_cyc - start, 32'd27);
        check("long_div", {27'd0, div_o}, 32'd5);

        // 5b. Long press while already at the default still strobes.
        p0 = pulse_cnt;
        btn_i = 1'b1; step(40);
        btn_i = 1'b0; step(20);
        check("long_same_pulses", pulse_cnt - p0, 32'd1);
        check("long_same_div", {27'd0, div_o}, 32'd5);

        // 6. Reset while in PRESSED, release during reset.
        do_reset();
        p0 = pulse_cnt;
        btn_i = 1'b1; step(10);
        rst   = 1'b1; step(2);
        btn_i = 1'b0; step(1);
        rst   = 1'b0; step(20);
        check("midrst_pulses", pulse_cnt - p0, 32'd0);
        check("midrst_div", {27'd0, div_o}, 32'd5);
        // A normal press right after shows the FSM is back in IDLE.
        p0 = pulse_cnt;
        short_press(10, 20);
        check("midrst_next_pulses", pulse_cnt - p0, 32'd1);
        check("midrst_next_latency", last_pulse_cyc - start, 32'd7);
        check("midrst_next_div", {27'd0, div_o}, 32'd6);

        // Strobe never high on two consecutive cycles over the whole run.
        check("no_consecutive_wren", consec_err, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
